flag_sched: RTL
===============

// Module: flag_sched
// PURPOSE
//  Issue-stage scheduler for conditional execution. Owns the architectural NZCV register.
//  Tracks in-flight flag writers (single- and multi-cycle ALU/MUL) and stalls any
//  instruction whose condition reads a flag group that is still pending.
//  Evaluates the condition once flags are stable and emits the CondEx result to execute.
//  Sits between decode and execute, alongside the per-instruction condition check.
// PARAMETERS
//  MAX_PEND  3  max outstanding writers per flag group (NZ, CV); counter width = $clog2(MAX_PEND+1)
// PORTS
//  clk          in   1  clock
//  reset_n      in   1  asynchronous reset, active low
//  d_valid      in   1  decode offers an instruction
//  d_ready      out  1  scheduler accepts (handshake completes on d_valid & d_ready)
//  d_cond       in   4  condition field (4'b1110 = AL)
//  d_flagwrite  in   2  [1]=writes NZ, [0]=writes CV
//  e_valid      out  1  issued-instruction strobe to execute (registered)
//  e_condex     out  1  condition result for the issued instruction
//  wb_valid     in   1  flag writeback from ALU/MUL
//  wb_flagwrite in   2  groups written by this writeback
//  wb_flags     in   4  {N,Z,C,V} result
//  flush        in   1  pipeline flush (branch taken)
//  flags        out  4  architectural NZCV
//  err_uflow    out  1  sticky: writeback arrived for a group with zero pending
// BEHAVIOUR
//  - Reset: flags=0, pend_nz=pend_cv=0, e_valid=0, e_condex=0, err_uflow=0. d_ready is
//    combinational and is 0 while reset_n=0.
//  - Read mask (cond -> groups): EQ/NE, MI/PL -> NZ; CS/CC, VS/VC -> CV;
//    HI/LS, GE/LT, GT/LE -> NZ|CV; AL -> none. 4'b1111 (undefined) -> NZ|CV, condex=0.
//  - Stall when (mask & {pend_nz!=0, pend_cv!=0}) != 0 (including fwd rule below).
//  - Stall when the writer's target group counter == MAX_PEND and no same-cycle wb
//    decrements that group.
//  - d_ready = !stall & !flush.
//  - Issue: on handshake, the next cycle has e_valid=1 and e_condex = cond(d_cond, flags_eval).
//    Otherwise e_valid=0 in the next cycle. Latency decode->execute = 1 cycle.
//  - Pending: a group counter increments on issue iff d_flagwrite bit set AND condex=1.
//    A squashed writer never increments.
//  - Writeback: wb_valid writes flags[group] for each set wb_flagwrite bit and decrements
//    that counter. Writebacks within a group are in order; NZ and CV may interleave.
//  - Same-cycle issue-increment and wb-decrement on one group: counter unchanged.
//  - wb to a group with counter 0: flags still written, counter stays 0, err_uflow<=1 (sticky until reset).
//  - flush: both counters <= 0, e_valid <= 0 next cycle, no issue this cycle.
//    A wb in the flush cycle still updates flags. Later orphan wbs set err_uflow.
//    Execute must drop them; err_uflow is diagnostic only.
//  - Reset mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  FLAG_SCHED_FWD_EN defined:
//    - flags_eval = flags with the same-cycle wb merged per group.
//    - A group with pend==1 being written back this cycle counts as not pending.
//    - Issue proceeds in the wb cycle.
//  Undefined:
//    - flags_eval = flags register.
//    - Issue waits until the cycle after the last wb (counter 0).
// STRUCTURE
//  flag_pkg: cond_e enum (EQ..AL), FLAG_NZ/FLAG_CV group index constants,
//  functions cond_eval(cond, nzcv) and cond_mask(cond) -> [1:0].
//  One sub-module: flag_pend_ctr (per-group counter: inc, dec, clr, full, nonzero,
//  uflow), instantiated twice.
// TESTING
//  1. AL, flagwrite=00, d_valid every cycle -> d_ready=1 always; e_valid each following cycle, e_condex=1.
//  2. Writer flagwrite=10 issued, then EQ with wb 3 cycles later (wb_flags=0100)
//     -> EQ stalls until wb; e_condex=1.
//     FWD_EN: issue in the wb cycle. Otherwise: issue one cycle later.
//  3. Writer fw=01 pending, then MI -> no stall (CV-only pending).
//     Then GT -> stalls until CV wb.
//  4. Issue MAX_PEND=3 NZ writers without wb -> 4th NZ writer sees d_ready=0.
//     wb in the same cycle -> accepted, counter stays 3.
//  5. NE writer with Z=1 (condex=0) -> pend_nz stays 0, e_condex=0.
//     Following EQ issues immediately.
//  6. Two NZ writers pending, flush -> counters 0, next-cycle e_valid=0.
//     Orphan wb -> flags updated, err_uflow=1.
//     Assert reset_n low mid-stall -> all outputs to reset values.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the conditional-execution flag scheduler:
// condition codes, flag group indices and condition evaluation helpers.
package flag_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    // Bit positions of the two flag groups in every 2-bit group vector.
    localparam int FLAG_NZ = 1;
    localparam int FLAG_CV = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = nzcv;
        case (cond_e'(cond))
            EQ:      res = z;
            NE:      res = ~z;
            CS:      res = c;
            CC:      res = ~c;
            MI:      res = n;
            PL:      res = ~n;
            VS:      res = v;
            VC:      res = ~v;
            HI:      res = c & ~z;
            LS:      res = ~c | z;
            GE:      res = (n == v);
            LT:      res = (n != v);
            GT:      res = ~z & (n == v);
            LE:      res = z | (n != v);
            AL:      res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Flag groups a condition reads; the undefined encoding conservatively reads both.
    function automatic logic [1:0] cond_mask(input logic [3:0] cond);
        logic [1:0] m;
        m = 2'b00;
        case (cond_e'(cond))
            EQ, NE, MI, PL: m[FLAG_NZ] = 1'b1;
            CS, CC, VS, VC: m[FLAG_CV] = 1'b1;
            AL:             m = 2'b00;
            default:        m = 2'b11;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_pend_ctr.sv
// Outstanding-writer counter for one flag group (NZ or CV).
// An underflowing decrement is flagged and otherwise ignored.
module flag_pend_ctr #(
    parameter int MAX_PEND = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic nonzero,
    output logic one,
    output logic uflow
);

    localparam int CW = $clog2(MAX_PEND + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        nonzero = (cnt_q != '0);
        full    = (cnt_q == CW'(MAX_PEND));
        one     = (cnt_q == CW'(1));
        uflow   = dec & ~nonzero;
        // A simultaneous inc and valid dec cancel out.
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(dec && nonzero)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && nonzero) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flag_sched.sv
// Issue-stage scheduler owning NZCV: stalls conditional instructions on pending flag groups.
// Define FLAG_SCHED_FWD_EN to evaluate conditions against same-cycle writeback flags.
module flag_sched
    import flag_pkg::*;
#(
    parameter int MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic [3:0] d_cond,
    input  logic [1:0] d_flagwrite,
    output logic       e_valid,
    output logic       e_condex,
    input  logic       wb_valid,
    input  logic [1:0] wb_flagwrite,
    input  logic [3:0] wb_flags,
    input  logic       flush,
    output logic [3:0] flags,
    output logic       err_uflow
);

`ifdef FLAG_SCHED_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [3:0] flags_q, flags_d, flags_wb, flags_eval;
    logic       e_valid_q, e_valid_d;
    logic       e_condex_q, e_condex_d;
    logic       err_uflow_q, err_uflow_d;

    logic       wb_nz, wb_cv;
    logic       nz_inc, cv_inc;
    logic       nz_full, cv_full, nz_nonzero, cv_nonzero, nz_one, cv_one;
    logic       nz_uflow, cv_uflow;
    logic       nz_busy, cv_busy;
    logic [1:0] rd_mask;
    logic       stall, condex, issue;

    always_comb begin
        wb_nz = wb_valid & wb_flagwrite[FLAG_NZ];
        wb_cv = wb_valid & wb_flagwrite[FLAG_CV];

        // With forwarding, the last outstanding writer retiring this cycle no longer blocks.
        nz_busy = nz_nonzero & ~(FWD_EN & wb_nz & nz_one);
        cv_busy = cv_nonzero & ~(FWD_EN & wb_cv & cv_one);

        flags_wb   = {wb_nz ? wb_flags[3:2] : flags_q[3:2],
                      wb_cv ? wb_flags[1:0] : flags_q[1:0]};
        flags_eval = FWD_EN ? flags_wb : flags_q;

        rd_mask = cond_mask(d_cond);
        stall   = (rd_mask[FLAG_NZ] & nz_busy)
                | (rd_mask[FLAG_CV] & cv_busy)
                | (d_flagwrite[FLAG_NZ] & nz_full & ~wb_nz)
                | (d_flagwrite[FLAG_CV] & cv_full & ~wb_cv);
        d_ready = reset_n & ~stall & ~flush;

        condex = cond_eval(d_cond, flags_eval);
        issue  = d_valid & d_ready;
        // Squashed writers never produce a writeback, so they are not counted.
        nz_inc = issue & d_flagwrite[FLAG_NZ] & condex;
        cv_inc = issue & d_flagwrite[FLAG_CV] & condex;

        flags_d     = flags_wb;
        e_valid_d   = issue;
        e_condex_d  = issue & condex;
        err_uflow_d = err_uflow_q | nz_uflow | cv_uflow;
    end

    flag_pend_ctr #(.MAX_PEND(MAX_PEND)) u_nz_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (nz_inc),
        .dec     (wb_nz),
        .clr     (flush),
        .full    (nz_full),
        .nonzero (nz_nonzero),
        .one     (nz_one),
        .uflow   (nz_uflow)
    );

    flag_pend_ctr #(.MAX_PEND(MAX_PEND)) u_cv_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cv_inc),
        .dec     (wb_cv),
        .clr     (flush),
        .full    (cv_full),
        .nonzero (cv_nonzero),
        .one     (cv_one),
        .uflow   (cv_uflow)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= 4'h0;
            e_valid_q   <= 1'b0;
            e_condex_q  <= 1'b0;
            err_uflow_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            e_valid_q   <= e_valid_d;
            e_condex_q  <= e_condex_d;
            err_uflow_q <= err_uflow_d;
        end
    end

    assign flags     = flags_q;
    assign e_valid   = e_valid_q;
    assign e_condex  = e_condex_q;
    assign err_uflow = err_uflow_q;

endmodule
